pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MC_TIMEOUT, default 64, max cycles to wait for the multi-cycle unit before abort.
REQ-002 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have id_rs1, id_rs2  input  5 each  source registers of instruction in ID.
REQ-006 SHALL have id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads that source.
REQ-007 SHALL have ex_rd  input  5  destination register of instruction in EX.
REQ-008 SHALL have ex_memread  input  1  EX instruction is a load.
REQ-009 SHALL have ex_is_mc  input  1  EX instruction is mul/div (multi-cycle).
REQ-010 SHALL have ex_br_taken  input  1  EX resolved a taken branch or jump.
REQ-011 SHALL have mc_done  input  1  multi-cycle unit result valid (single-cycle pulse).
REQ-012 SHALL have pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold  output  1 each  pipeline register controls.
REQ-013 SHALL have mc_start  output  1  one-cycle start pulse to the multi-cycle unit.
REQ-014 SHALL have mc_err  output  1  one-cycle pulse on multi-cycle timeout.
REQ-015 SHALL have stall_cnt, flush_cnt  output  CNT_W each  performance counters (only with PIPE_CTRL_PERF_EN).

Function
REQ-016 SHALL implement a registered FSM with states RUN and MC_WAIT; all control outputs are combinational from state and inputs.
REQ-017 Default in RUN with no event: pc_write=1, if_id_write=1, others 0.
REQ-018 Load-use: ex_memread=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd) SHALL give pc_write=0, if_id_write=0, id_ex_bubble=1 for that cycle.
REQ-019 Branch: ex_br_taken=1 in RUN SHALL give if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; overrides load-use.
REQ-020 Multi-cycle: ex_is_mc=1 in RUN (no branch) SHALL assert mc_start, pc_write=0, if_id_write=0, ex_hold=1 and move to MC_WAIT next cycle; overrides load-use.
REQ-021 MC_WAIT: pc_write=0, if_id_write=0, ex_hold=1, id_ex_bubble=0, mc_start=0; ex_br_taken and load-use ignored.
REQ-022 MC_WAIT with mc_done=1: that cycle releases (pc_write=1, if_id_write=1, ex_hold=0); next state RUN.
REQ-023 Wait counter clears on entry to MC_WAIT, increments each MC_WAIT cycle; at MC_TIMEOUT-1 without mc_done SHALL pulse mc_err, release as REQ-022, return RUN.
REQ-024 mc_done while in RUN SHALL be ignored.
REQ-025 Wait counter width SHALL be clog2(MC_TIMEOUT).

Reset
REQ-026 rst SHALL force state RUN, wait counter 0, perf counters 0, in the same clock edge, including mid-MC_WAIT.
REQ-027 While rst=1, outputs SHALL be pc_write=0, if_id_write=0, all others 0.

Configuration
REQ-028 With PIPE_CTRL_PERF_EN defined: stall_cnt increments each cycle pc_write=0 (rst low); flush_cnt increments each cycle if_id_flush=1; both saturate at all-ones.
REQ-029 Without PIPE_CTRL_PERF_EN: counters and their registers absent; stall_cnt/flush_cnt ports tied to 0.

Structure
REQ-030 Shared package pipe_pkg SHALL hold FSM state enum (RUN, MC_WAIT) and constant REG_ZERO=5'd0.
REQ-031 One sub-module pipe_perf_cnt (saturating counter, CNT_W) SHALL be instantiated twice under the macro; hazard/FSM logic stays in pipe_ctrl.

Verification
REQ-032 ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle.
REQ-033 Same as REQ-032 but ex_rd=0, or id_use_rs1=0 -> no stall.
REQ-034 ex_br_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1.
REQ-035 ex_is_mc=1, mc_done after 10 cycles -> mc_start one pulse, 11 stall cycles total, RUN afterwards; with macro stall_cnt=11.
REQ-036 MC_TIMEOUT=8, mc_done never -> mc_err pulse after 8 MC_WAIT cycles, return RUN.
REQ-037 rst asserted in 3rd MC_WAIT cycle -> next cycle state RUN, counters 0, no mc_err.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones,
// cleared by synchronous active-high rst.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step on an event unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// multi-cycle (mul/div) wait with timeout abort.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters;
// without it the counter ports are tied to zero.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_is_mc,
  input  logic             ex_br_taken,
  input  logic             mc_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             mc_start,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              load_use;

  // A load in EX whose (non-zero) destination feeds a source ID actually reads.
  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Next state and all pipeline controls from current state and inputs.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    mc_start     = 1'b0;
    mc_err       = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_is_mc) begin
            mc_start   = 1'b1;
            ex_hold    = 1'b1;
            state_d    = MC_WAIT;
            wait_cnt_d = '0;
          end else if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            mc_err      = 1'b1;
            state_d     = RUN;
          end else begin
            ex_hold    = 1'b1;
            wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and wait-counter registers; reset also aborts a pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!rst && !pc_write),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (if_id_flush),
    .cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (timeout 64 / 32-bit counters and
// timeout 8 / 4-bit counters) share stimulus; a cycle-level reference model
// checks both every cycle, and directed sequences pin literal values.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_is_mc, ex_br_taken, mc_done;

  logic        a_pc, a_ifid, a_flush, a_bub, a_hold, a_start, a_err;
  logic [31:0] a_stall, a_fcnt;
  logic        b_pc, b_ifid, b_flush, b_bub, b_hold, b_start, b_err;
  logic [3:0]  b_stall, b_fcnt;

  pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_is_mc(ex_is_mc), .ex_br_taken(ex_br_taken),
    .mc_done(mc_done), .pc_write(a_pc), .if_id_write(a_ifid),
    .if_id_flush(a_flush), .id_ex_bubble(a_bub), .ex_hold(a_hold),
    .mc_start(a_start), .mc_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_fcnt)
  );

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_is_mc(ex_is_mc), .ex_br_taken(ex_br_taken),
    .mc_done(mc_done), .pc_write(b_pc), .if_id_write(b_ifid),
    .if_id_flush(b_flush), .id_ex_bubble(b_bub), .ex_hold(b_hold),
    .mc_start(b_start), .mc_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_fcnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: outputs {pc,ifid,flush,bubble,hold,start,err} for timeout T,
  // given whether a multi-cycle op is pending and how many wait cycles elapsed.
  function automatic void model(input int T, input bit waiting, input int waited,
                                output logic [6:0] o, output bit nwait, output int nwaited);
    bit hazard;
    o       = 7'b0;
    nwait   = waiting;
    nwaited = waited;
    hazard  = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      nwait   = 1'b0;
      nwaited = 0;
    end else if (!waiting) begin
      if (ex_br_taken)   o = 7'b1111000;
      else if (ex_is_mc) begin o = 7'b0000110; nwait = 1'b1; nwaited = 0; end
      else if (hazard)   o = 7'b0001000;
      else               o = 7'b1100000;
    end else begin
      if (mc_done)               begin o = 7'b1100000; nwait = 1'b0; end
      else if (waited == T - 1)  begin o = 7'b1100001; nwait = 1'b0; end
      else                       begin o = 7'b0000100; nwaited = waited + 1; end
    end
  endfunction

  task automatic upd(input logic [6:0] eo, input longint maxv,
                     inout longint sc, inout longint fc);
`ifdef PIPE_CTRL_PERF_EN
    if (rst) begin
      sc = 0;
      fc = 0;
    end else begin
      if (!eo[6] && sc < maxv) sc++;
      if (eo[4] && fc < maxv) fc++;
    end
`endif
  endtask

  bit     a_wait = 0, b_wait = 0;
  int     a_waited = 0, b_waited = 0;
  longint a_sc = 0, a_fc = 0, b_sc = 0, b_fc = 0;

  // Per-cycle comparison against the model, then model advance.
  initial begin
    logic [6:0] eo;
    bit         nw;
    int         nn;
    forever begin
      @(negedge clk);
      model(64, a_wait, a_waited, eo, nw, nn);
      chk("A_ctrl", {a_pc, a_ifid, a_flush, a_bub, a_hold, a_start, a_err}, eo);
      chk("A_stall_cnt", a_stall, a_sc);
      chk("A_flush_cnt", a_fcnt, a_fc);
      upd(eo, 64'hFFFF_FFFF, a_sc, a_fc);
      a_wait = nw; a_waited = nn;

      model(8, b_wait, b_waited, eo, nw, nn);
      chk("B_ctrl", {b_pc, b_ifid, b_flush, b_bub, b_hold, b_start, b_err}, eo);
      chk("B_stall_cnt", b_stall, b_sc);
      chk("B_flush_cnt", b_fcnt, b_fc);
      upd(eo, 15, b_sc, b_fc);
      b_wait = nw; b_waited = nn;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_is_mc = 1'b0; ex_br_taken = 1'b0; mc_done = 1'b0;
  endtask

  int stalls, starts, seen;

  initial begin
    rst = 1'b1;
    idle();
    // Reset state: everything low, including pc_write.
    step(); step(); #6;
    chk("rst_pc", a_pc, 0);
    chk("rst_ifid", a_ifid, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_stall_cnt", a_stall, 0);

    step(); rst = 1'b0; #6;
    chk("idle_pc", a_pc, 1);
    chk("idle_ifid", a_ifid, 1);

    // Load-use hazard on rs1.
    step(); ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #6;
    chk("lu_pc", a_pc, 0);
    chk("lu_ifid", a_ifid, 0);
    chk("lu_bubble", a_bub, 1);

    // Destination x0 never stalls.
    step(); ex_rd = 5'd0; id_rs1 = 5'd0; #6;
    chk("lu_x0_pc", a_pc, 1);
    chk("lu_x0_bubble", a_bub, 0);

    // Unused source never stalls.
    step(); ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; #6;
    chk("lu_unused_pc", a_pc, 1);
    chk("lu_unused_bubble", a_bub, 0);

    // Taken branch overrides load-use.
    step(); id_use_rs1 = 1'b1; ex_br_taken = 1'b1; #6;
    chk("br_flush", a_flush, 1);
    chk("br_bubble", a_bub, 1);
    chk("br_pc", a_pc, 1);
    chk("br_ifid", a_ifid, 1);

    // Multi-cycle op completing 10 cycles after start.
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0; ex_is_mc = 1'b1; #6;
    chk("mc_start_pulse", a_start, 1);
    stalls = a_pc ? 0 : 1;
    starts = a_start ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      step(); ex_is_mc = 1'b0; mc_done = (i == 11); #6;
      if (!a_pc) stalls++;
      if (a_start) starts++;
      if (i == 11) begin
        chk("mc_release_pc", a_pc, 1);
        chk("mc_release_hold", a_hold, 0);
`ifdef PIPE_CTRL_PERF_EN
        chk("mc_stall_cnt", a_stall, 11);
`endif
      end
    end
    chk("mc_stall_cycles", stalls, 11);
    chk("mc_start_count", starts, 1);
    chk("mc_run_after", a_pc, 1);

    // Timeout on the MC_TIMEOUT=8 instance.
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0; ex_is_mc = 1'b1;
    seen = 0;
    for (int w = 1; w <= 20; w++) begin
      step(); ex_is_mc = 1'b0; #6;
      if (b_err) begin
        seen = w;
        chk("to_release_pc", b_pc, 1);
        break;
      end
    end
    chk("to_wait_cycles", seen, 8);
    step(); #6;
    chk("to_run_pc", b_pc, 1);
    chk("to_run_hold", b_hold, 0);
    chk("to_err_once", b_err, 0);

    // Reset in the third wait cycle aborts cleanly.
    step(); ex_is_mc = 1'b1;
    step(); ex_is_mc = 1'b0;
    step();
    step(); rst = 1'b1; #6;
    chk("rstw_pc", a_pc, 0);
    chk("rstw_hold", a_hold, 0);
    chk("rstw_err_a", a_err, 0);
    chk("rstw_err_b", b_err, 0);
    step(); rst = 1'b0; #6;
    chk("rstw_run_pc", a_pc, 1);
    chk("rstw_run_hold", a_hold, 0);
    chk("rstw_stall_cnt", a_stall, 0);
    chk("rstw_flush_cnt_b", b_fcnt, 0);

    // Randomized traffic; register indices from a small set to force matches.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst         = ($urandom_range(0, 99) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = ($urandom_range(0, 3) != 0);
      id_use_rs2  = ($urandom_range(0, 3) != 0);
      ex_memread  = ($urandom_range(0, 1) == 1);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      ex_is_mc    = ($urandom_range(0, 7) == 0);
      mc_done     = (i < 2000) ? ($urandom_range(0, 3) == 0)
                               : ($urandom_range(0, 39) == 0);
    end

    step(); idle(); rst = 1'b0;
    step(); #6;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
